// File: rtl/registro_temp_pkg.sv
// Shared constants and types for the temperature front end and its consumer FSM.
// No logic; types and helpers only.
// Not applicable.
package pkg_temp;

  localparam int ANCHO_TEMP = 11;

  // Normal range limits and special values, in tenths of a degree.
  localparam logic signed [ANCHO_TEMP-1:0] TEMP_BAJO    = 11'sd180;
  localparam logic signed [ANCHO_TEMP-1:0] TEMP_ALTO    = 11'sd259;
  localparam logic signed [ANCHO_TEMP-1:0] TEMP_INICIAL = 11'sd220;
  localparam logic signed [ANCHO_TEMP-1:0] CODIGO_ERROR = 11'b100_0000_0000;

  // Persistence threshold used by the downstream temperature-state FSM.
  localparam int N = 5;

  // Downstream temperature-state FSM states.
  typedef enum logic [1:0] {TEMP_NORMAL, TEMP_FRIO, TEMP_CALOR} estado_temp_t;

  // Conditioning block states.
  typedef enum logic [1:0] {LLENADO, OPERACION, FALLA} estado_reg_t;

  // Out-of-range persistence: saturating increment outside the range, clear inside.
  function automatic logic [2:0] regla_contador(input logic signed [ANCHO_TEMP-1:0] prom,
                                                 input logic [2:0] cont);
    if (prom < TEMP_BAJO || prom > TEMP_ALTO)
      return (cont == 3'd7) ? 3'd7 : cont + 3'd1;
    else
      return 3'd0;
  endfunction

endpackage

// File: rtl/registro_temp_if.sv
// Sample handshake between the sensor scaler and the conditioning block.
// No logic.
// Sample accepted when muestra_valida && muestra_lista at posedge.
interface registro_temp_if;
  import pkg_temp::*;

  logic                         muestra_valida;
  logic signed [ANCHO_TEMP-1:0] muestra;
  logic                         muestra_lista;

  modport master (output muestra_valida, output muestra, input muestra_lista);
  modport slave  (input muestra_valida, input muestra, output muestra_lista);

endinterface

// File: rtl/registro_temp_promedio_movil.sv
// Moving-average window: shift register, running sum and the average including the incoming sample.
// promedio is combinational from the current input; window/sum update on the shift edge.
// No backpressure; shifts whenever shift_en is high.
module promedio_movil
  import pkg_temp::*;
#(
  parameter int PROM_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         shift_en,
  input  logic                         flush,
  input  logic signed [ANCHO_TEMP-1:0] muestra,
  output logic signed [ANCHO_TEMP-1:0] promedio
);

  localparam int VENTANA    = 1 << PROM_LOG2;
  localparam int ANCHO_SUMA = ANCHO_TEMP + PROM_LOG2;

  logic signed [ANCHO_TEMP-1:0] ventana_q [VENTANA];
  logic signed [ANCHO_SUMA-1:0] suma_q;
  logic signed [ANCHO_SUMA-1:0] muestra_ext;
  logic signed [ANCHO_SUMA-1:0] saliente_ext;
  logic signed [ANCHO_SUMA-1:0] suma_d;

  assign muestra_ext  = {{PROM_LOG2{muestra[ANCHO_TEMP-1]}}, muestra};
  assign saliente_ext = {{PROM_LOG2{ventana_q[VENTANA-1][ANCHO_TEMP-1]}}, ventana_q[VENTANA-1]};
  assign suma_d       = suma_q + muestra_ext - saliente_ext;
  // Arithmetic shift floors toward -inf for negative sums.
  assign promedio     = ANCHO_TEMP'(suma_d >>> PROM_LOG2);

  // Window and running sum; flush restarts the window, optionally with the incoming sample.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < VENTANA; i++) ventana_q[i] <= '0;
      suma_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < VENTANA; i++) ventana_q[i] <= '0;
      if (shift_en) begin
        ventana_q[0] <= muestra;
        suma_q       <= muestra_ext;
      end else begin
        suma_q <= '0;
      end
    end else if (shift_en) begin
      for (int i = 1; i < VENTANA; i++) ventana_q[i] <= ventana_q[i-1];
      ventana_q[0] <= muestra;
      suma_q       <= suma_d;
    end
  end

endmodule

// File: rtl/registro_temp.sv
// Temperature conditioning: 4-sample average, out-of-range persistence count, sample-timeout fault.
// Outputs update on the posedge that accepts a good sample, visible the following cycle.
// Always ready out of reset; error-code samples are accepted and dropped.
module registro_temp
  import pkg_temp::*;
#(
  parameter int TIMEOUT   = 1000,
  parameter int PROM_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         arst_n,
  registro_temp_if.slave               bus,
  output logic signed [ANCHO_TEMP-1:0] temp_registrado,
  output logic [2:0]                   contador_fuera_rango,
  output logic                         temp_valida,
  output logic                         sensor_falla
);

  localparam int VENTANA = 1 << PROM_LOG2;
  localparam int LLEN_W  = $clog2(VENTANA + 1);
  localparam int TOUT_W  = $clog2(TIMEOUT + 1);

  estado_reg_t                  estado_q, estado_d;
  logic signed [ANCHO_TEMP-1:0] temp_d;
  logic [2:0]                   cont_d;
  logic                         valida_d, falla_d;
  logic [TOUT_W-1:0]            tout_q, tout_d, tout_inc;
  logic [LLEN_W-1:0]            llen_q, llen_d;
  logic                         shift_en, flush, bueno;
  logic signed [ANCHO_TEMP-1:0] promedio;

  // Ready drops only while reset is held.
  assign bus.muestra_lista = arst_n;
  assign bueno    = bus.muestra_valida && bus.muestra_lista && (bus.muestra != CODIGO_ERROR);
  assign tout_inc = tout_q + TOUT_W'(1);

  promedio_movil #(.PROM_LOG2(PROM_LOG2)) u_promedio (
    .clk      (clk),
    .arst_n   (arst_n),
    .shift_en (shift_en),
    .flush    (flush),
    .muestra  (bus.muestra),
    .promedio (promedio)
  );

  // State, outputs and counters register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado_q             <= LLENADO;
      temp_registrado      <= TEMP_INICIAL;
      contador_fuera_rango <= '0;
      temp_valida          <= 1'b0;
      sensor_falla         <= 1'b0;
      tout_q               <= '0;
      llen_q               <= '0;
    end else begin
      estado_q             <= estado_d;
      temp_registrado      <= temp_d;
      contador_fuera_rango <= cont_d;
      temp_valida          <= valida_d;
      sensor_falla         <= falla_d;
      tout_q               <= tout_d;
      llen_q               <= llen_d;
    end
  end

  // Next-state, window control and output update; a good sample beats timeout expiry.
  always_comb begin
    estado_d = estado_q;
    temp_d   = temp_registrado;
    cont_d   = contador_fuera_rango;
    valida_d = temp_valida;
    falla_d  = sensor_falla;
    tout_d   = tout_q;
    llen_d   = llen_q;
    shift_en = 1'b0;
    flush    = 1'b0;
    case (estado_q)
      LLENADO: begin
        if (bueno) begin
          shift_en = 1'b1;
          tout_d   = '0;
          llen_d   = llen_q + LLEN_W'(1);
          if (llen_q == LLEN_W'(VENTANA - 1)) begin
            estado_d = OPERACION;
            temp_d   = promedio;
            valida_d = 1'b1;
            cont_d   = regla_contador(promedio, contador_fuera_rango);
          end
        end else if (tout_inc == TOUT_W'(TIMEOUT)) begin
          estado_d = FALLA;
          falla_d  = 1'b1;
          valida_d = 1'b0;
          tout_d   = '0;
        end else begin
          tout_d = tout_inc;
        end
      end
      OPERACION: begin
        if (bueno) begin
          shift_en = 1'b1;
          tout_d   = '0;
          temp_d   = promedio;
          cont_d   = regla_contador(promedio, contador_fuera_rango);
        end else if (tout_inc == TOUT_W'(TIMEOUT)) begin
          estado_d = FALLA;
          falla_d  = 1'b1;
          valida_d = 1'b0;
          tout_d   = '0;
        end else begin
          tout_d = tout_inc;
        end
      end
      FALLA: begin
        // First good sample restarts filling with itself as sample one.
        if (bueno) begin
          flush    = 1'b1;
          shift_en = 1'b1;
          llen_d   = LLEN_W'(1);
          cont_d   = '0;
          falla_d  = 1'b0;
          temp_d   = TEMP_INICIAL;
          tout_d   = '0;
          estado_d = LLENADO;
        end
      end
      default: begin
        estado_d = LLENADO;
        flush    = 1'b1;
        temp_d   = TEMP_INICIAL;
        cont_d   = '0;
        valida_d = 1'b0;
        falla_d  = 1'b0;
        tout_d   = '0;
        llen_d   = '0;
      end
    endcase
  end

endmodule
